adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one external adder datapath (operands `data_width` bits, sum `data_width+1` bits) among `num_req` requesters.
- Arbitration is round-robin. A granted operation holds the adder operands stable for `add_latency` cycles, then captures the sum and returns it to the owning requester with a one-cycle valid pulse.
- Sits between test/stimulus masters (or datapath clients) and the shared adder instance.

Parameters:
- data_width, 8, operand width in bits; sum width is data_width+1
- num_req, 4, number of requesters (2..16)
- add_latency, 1, cycles from add_a/add_b change until add_sum is valid (1..15)

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately; release is synchronous to clk)
- req  input  num_req  per-requester request; held high with operands until gnt
- req_a  input  num_req*data_width  flattened operand A; slice i = requester i
- req_b  input  num_req*data_width  flattened operand B; slice i = requester i
- gnt  output  num_req  one-hot, one-cycle pulse: operands of requester i accepted
- rsp_valid  output  num_req  one-hot, one-cycle pulse: rsp_sum belongs to requester i
- rsp_sum  output  data_width+1  shared result bus; valid only while rsp_valid != 0
- add_a  output  data_width  operand A to the shared adder
- add_b  output  data_width  operand B to the shared adder
- add_sum  input  data_width+1  adder result, unsigned, carry in MSB
- busy  output  1  high while an operation is in flight (state != IDLE)

Behaviour:
- Reset (rst=0):
  - gnt, rsp_valid, rsp_sum, add_a, add_b, busy all 0.
  - State IDLE, rr pointer 0, latency counter 0, owner 0.
  - Reset mid-operation aborts the operation silently; no rsp_valid is issued.
- FSM states: IDLE and WAIT.
- IDLE:
  - If req != 0 at a posedge, select the first asserted requester scanning from pointer upward, with wrap-around modulo num_req.
  - Register add_a/add_b from that requester's slices, pulse gnt[sel] for one cycle, set owner=sel, set counter=add_latency, and go to WAIT.
  - If req == 0, stay in IDLE; add_a and add_b hold their last values.
- WAIT:
  - Decrement the counter each posedge. add_a and add_b are held constant; req is ignored.
  - When the counter would reach 0 (the posedge add_latency cycles after the grant edge), register rsp_sum=add_sum and pulse rsp_valid[owner].
  - On that same edge, set pointer=(owner+1) mod num_req and return to IDLE.
- Timing:
  - Grant at edge k gives rsp_valid at edge k+add_latency.
  - The earliest next grant is at edge k+add_latency+1.
  - Throughput is one operation per add_latency+1 cycles.
- Arithmetic: the block does no arithmetic on data. rsp_sum is a verbatim copy of add_sum, including the carry bit.
- Request rules:
  - A req dropped before its gnt is withdrawn and has no effect.
  - After gnt, the requester may change req_a/req_b or deassert req.
  - A req still high after gnt is treated as a new request.
- rsp_valid and gnt never pulse for more than one requester at a time. They never coincide in the same cycle, because a grant only occurs from IDLE.
- The pointer advances only on completion, never on a withdrawn request.

Optional Feature:
- Macro: ADDER_SHARE_ARB_FIXED_PRIORITY_EN.
- Defined: arbitration is fixed priority. The lowest-index asserted req always wins, and the pointer register is removed.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset mid-op: grant req0 (a=10, b=20), then drive rst=0 during WAIT -> all outputs 0 immediately, no rsp_valid after release, next grant begins from requester 0.
- Single op: req[0]=1, a=200, b=100, latency 1 -> gnt=4'b0001 after edge k, add_a=200, add_b=100; rsp_valid=4'b0001 with rsp_sum=9'd300 after edge k+1.
- Carry: req[2]=1, a=255, b=255 -> rsp_valid=4'b0100, rsp_sum=9'd510 (MSB set).
- All requesting: req=4'b1111 held, each dropped after its gnt -> gnts 0,1,2,3 spaced exactly 2 cycles apart, each rsp_sum matching its own operands.
- Fairness: req[0] and req[2] held continuously -> grant order 0,2,0,2,…. With ADDER_SHARE_ARB_FIXED_PRIORITY_EN defined -> 0,0,0,….
- add_latency=3, single op: gnt at edge k -> add_a/add_b stable for 3 cycles, rsp_valid at edge k+3, busy high across edges k..k+2, next grant no earlier than k+4.

Source files
------------

// File: rtl/adder_share_arbiter_if.sv
// Bus bundle between the requesting clients, the arbiter and the shared adder.
// The master side drives requests and the adder result. The slave side is the arbiter.
interface adder_share_arbiter_if #(
    parameter int data_width = 8,
    parameter int num_req    = 4
);
    logic [num_req-1:0]            req;
    logic [num_req*data_width-1:0] req_a;
    logic [num_req*data_width-1:0] req_b;
    logic [num_req-1:0]            gnt;
    logic [num_req-1:0]            rsp_valid;
    logic [data_width:0]           rsp_sum;
    logic [data_width-1:0]         add_a;
    logic [data_width-1:0]         add_b;
    logic [data_width:0]           add_sum;

    modport master (
        output req, req_a, req_b, add_sum,
        input  gnt, rsp_valid, rsp_sum, add_a, add_b
    );

    modport slave (
        input  req, req_a, req_b, add_sum,
        output gnt, rsp_valid, rsp_sum, add_a, add_b
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one multi-cycle adder among num_req requesters.
// Define ADDER_SHARE_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration without a pointer.
module adder_share_arbiter #(
    parameter int data_width  = 8,
    parameter int num_req     = 4,
    parameter int add_latency = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_share_arbiter_if.slave bus,
    output logic                 busy
);
    localparam int PW = $clog2(num_req);
    localparam int CW = 4;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [data_width-1:0] add_a_q, add_a_d;
    logic [data_width-1:0] add_b_q, add_b_d;
    logic [num_req-1:0]    gnt_q, gnt_d;
    logic [num_req-1:0]    rsp_valid_q, rsp_valid_d;
    logic [data_width:0]   rsp_sum_q, rsp_sum_d;
    logic [PW-1:0]         sel;
    logic                  sel_vld;
    logic                  done;

    // Last WAIT cycle: the adder result is valid at this edge.
    assign done = (state_q == WAIT) && (cnt_q == CW'(1));

`ifdef ADDER_SHARE_ARB_FIXED_PRIORITY_EN
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int i = num_req - 1; i >= 0; i--) begin
            if (bus.req[i[PW-1:0]]) begin
                sel     = i[PW-1:0];
                sel_vld = 1'b1;
            end
        end
    end
`else
    logic [PW-1:0] ptr_q, ptr_d;

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        int idx;
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        for (int off = num_req - 1; off >= 0; off--) begin
            idx = (int'(ptr_q) + off) % num_req;
            if (bus.req[idx[PW-1:0]]) begin
                sel     = idx[PW-1:0];
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (done) begin
            ptr_d = (owner_q == PW'(num_req - 1)) ? '0 : owner_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_vld) state_d = WAIT;
            WAIT:    if (done)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_sum_d   = rsp_sum_q;
        if ((state_q == IDLE) && sel_vld) begin
            cnt_d      = CW'(add_latency);
            owner_d    = sel;
            add_a_d    = bus.req_a[sel*data_width +: data_width];
            add_b_d    = bus.req_b[sel*data_width +: data_width];
            gnt_d[sel] = 1'b1;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q - CW'(1);
            if (done) begin
                rsp_sum_d            = bus.add_sum;
                rsp_valid_d[owner_q] = 1'b1;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench: two arbiters (adder latency 1 and 3) share one random/directed stimulus.
// A time-stamped reference model predicts grants and responses; a monitor checks every cycle.
`timescale 1ns/1ps
module tb_adder_share_arbiter;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int PW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.data_width(DW), .num_req(N)) bus0 ();
    adder_share_arbiter_if #(.data_width(DW), .num_req(N)) bus1 ();
    logic busy0, busy1;

    adder_share_arbiter #(.data_width(DW), .num_req(N), .add_latency(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave), .busy(busy0));
    adder_share_arbiter #(.data_width(DW), .num_req(N), .add_latency(3)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .busy(busy1));

    logic [N-1:0]    req_v;
    logic [DW-1:0]   a_v [N];
    logic [DW-1:0]   b_v [N];
    logic [N*DW-1:0] pa, pb;

    always_comb begin
        pa = '0;
        pb = '0;
        for (int i = 0; i < N; i++) begin
            pa[i*DW +: DW] = a_v[i];
            pb[i*DW +: DW] = b_v[i];
        end
    end
    assign bus0.req = req_v;
    assign bus1.req = req_v;
    assign bus0.req_a = pa;
    assign bus1.req_a = pa;
    assign bus0.req_b = pb;
    assign bus1.req_b = pb;

    // Shared adders: combinational for latency 1, two register stages for latency 3.
    logic [DW:0] s1, s2;
    assign bus0.add_sum = {1'b0, bus0.add_a} + {1'b0, bus0.add_b};
    always @(posedge clk) begin
        s1 <= {1'b0, bus1.add_a} + {1'b0, bus1.add_b};
        s2 <= s1;
    end
    assign bus1.add_sum = s2;

    typedef struct { int cyc; int who; int a; int b; } gev_t;
    typedef struct { int cyc; int who; int sum; } rev_t;
    gev_t gq0[$], gq1[$];
    rev_t rq0[$], rq1[$];

    int lat [2] = '{1, 3};
    int ptr [2];
    int free_at [2];
    int gstart [2];
    int ga [2];
    int gb [2];
    int edge_cnt = 0;
    int total = 0;
    int bad = 0;
    int win0;

    initial forever begin
        @(posedge clk);
        edge_cnt = edge_cnt + 1;
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d edge=%0d got=%0h want=%0h", nm, d, edge_cnt, act, exp);
        end
    endtask

    function automatic int pick(input int d, input logic [N-1:0] r);
        int s;
        int idx;
`ifdef ADDER_SHARE_ARB_FIXED_PRIORITY_EN
        s = 0;
`else
        s = ptr[d];
`endif
        for (int k = 0; k < N; k++) begin
            idx = (s + k) % N;
            if (r[idx[PW-1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        gq0.delete(); gq1.delete(); rq0.delete(); rq1.delete();
        for (int d = 0; d < 2; d++) begin
            ptr[d] = 0;
            free_at[d] = 0;
            gstart[d] = -1000;
        end
    endtask

    // Predicts what each DUT does at the coming edge, then advances to the next negedge.
    task automatic tick();
        int n, w;
        gev_t ge;
        rev_t re;
        n = edge_cnt + 1;
        win0 = -1;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                if (n >= free_at[d]) begin
                    w = pick(d, req_v);
                    if (w >= 0) begin
                        ge.cyc = n; ge.who = w; ge.a = int'(a_v[w]); ge.b = int'(b_v[w]);
                        re.cyc = n + lat[d]; re.who = w; re.sum = int'(a_v[w]) + int'(b_v[w]);
                        if (d == 0) begin gq0.push_back(ge); rq0.push_back(re); win0 = w; end
                        else        begin gq1.push_back(ge); rq1.push_back(re); end
                        free_at[d] = n + lat[d] + 1;
                        ptr[d] = (w + 1) % N;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic check_dut(input int d, input logic [N-1:0] g, input logic [N-1:0] rv,
                             input logic [DW:0] rs, input logic [DW-1:0] aa,
                             input logic [DW-1:0] ab, input logic bz);
        int n;
        bit hg, hr, bexp;
        gev_t ge;
        rev_t re;
        n = edge_cnt;
        hg = 0;
        hr = 0;
        if (d == 0) begin
            if (gq0.size() > 0 && gq0[0].cyc == n) begin ge = gq0.pop_front(); hg = 1; end
            if (rq0.size() > 0 && rq0[0].cyc == n) begin re = rq0.pop_front(); hr = 1; end
        end else begin
            if (gq1.size() > 0 && gq1[0].cyc == n) begin ge = gq1.pop_front(); hg = 1; end
            if (rq1.size() > 0 && rq1[0].cyc == n) begin re = rq1.pop_front(); hr = 1; end
        end
        if (hg) begin
            gstart[d] = n;
            ga[d] = ge.a;
            gb[d] = ge.b;
            chk("gnt", d, 32'(g), 32'(1) << ge.who);
        end else begin
            chk("gnt_idle", d, 32'(g), 32'd0);
        end
        if (hr) begin
            chk("rsp_valid", d, 32'(rv), 32'(1) << re.who);
            chk("rsp_sum", d, 32'(rs), 32'(re.sum));
        end else begin
            chk("rsp_valid_idle", d, 32'(rv), 32'd0);
        end
        bexp = (n >= gstart[d]) && (n < gstart[d] + lat[d]);
        chk("busy", d, 32'(bz), 32'(bexp));
        if (bexp) begin
            chk("add_a_held", d, 32'(aa), 32'(ga[d]));
            chk("add_b_held", d, 32'(ab), 32'(gb[d]));
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        check_dut(0, bus0.gnt, bus0.rsp_valid, bus0.rsp_sum, bus0.add_a, bus0.add_b, busy0);
        check_dut(1, bus1.gnt, bus1.rsp_valid, bus1.rsp_sum, bus1.add_a, bus1.add_b, busy1);
    end

    task automatic check_reset_outputs();
        chk("rst_gnt", 0, 32'(bus0.gnt), 32'd0);
        chk("rst_rsp_valid", 0, 32'(bus0.rsp_valid), 32'd0);
        chk("rst_rsp_sum", 0, 32'(bus0.rsp_sum), 32'd0);
        chk("rst_add_a", 0, 32'(bus0.add_a), 32'd0);
        chk("rst_add_b", 0, 32'(bus0.add_b), 32'd0);
        chk("rst_busy", 0, 32'(busy0), 32'd0);
        chk("rst_gnt", 1, 32'(bus1.gnt), 32'd0);
        chk("rst_rsp_valid", 1, 32'(bus1.rsp_valid), 32'd0);
        chk("rst_rsp_sum", 1, 32'(bus1.rsp_sum), 32'd0);
        chk("rst_add_a", 1, 32'(bus1.add_a), 32'd0);
        chk("rst_add_b", 1, 32'(bus1.add_b), 32'd0);
        chk("rst_busy", 1, 32'(busy1), 32'd0);
    endtask

    task automatic idle(input int cycles);
        req_v = '0;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d got=timeout want=finish", edge_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_v = '0;
        for (int i = 0; i < N; i++) begin a_v[i] = '0; b_v[i] = '0; end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // All four requesting; each drops its request once granted.
        for (int i = 0; i < N; i++) begin
            a_v[i] = DW'(i * 40 + 5);
            b_v[i] = DW'(250 - i * 30);
        end
        req_v = '1;
        for (int i = 0; i < 20 && req_v != '0; i++) begin
            tick();
            if (win0 >= 0) req_v[win0] = 1'b0;
        end
        idle(5);

        // Single op on requester 0.
        a_v[0] = 8'd200; b_v[0] = 8'd100; req_v = 4'b0001;
        tick();
        idle(5);

        // Carry out of the adder on requester 2.
        a_v[2] = 8'd255; b_v[2] = 8'd255; req_v = 4'b0100;
        tick();
        idle(5);

        // Two requesters held continuously.
        req_v = 4'b0101;
        for (int i = 0; i < 12; i++) begin
            a_v[0] = DW'($urandom); b_v[0] = DW'($urandom);
            a_v[2] = DW'($urandom); b_v[2] = DW'($urandom);
            tick();
        end
        idle(5);

        // Reset asserted while the operation is in flight.
        a_v[0] = 8'd10; b_v[0] = 8'd20; req_v = 4'b0001;
        tick();
        req_v = '0;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        a_v[0] = 8'd1; b_v[0] = 8'd2; a_v[1] = 8'd3; b_v[1] = 8'd4;
        req_v = 4'b0011;
        tick();
        idle(5);

        // Random traffic, including withdrawn requests.
        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < N; j++) begin
                a_v[j] = DW'($urandom);
                b_v[j] = DW'($urandom);
            end
            req_v = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req_v = '0;
            tick();
        end
        idle(8);

        chk("gq_drained", 0, 32'(gq0.size()), 32'd0);
        chk("rq_drained", 0, 32'(rq0.size()), 32'd0);
        chk("gq_drained", 1, 32'(gq1.size()), 32'd0);
        chk("rq_drained", 1, 32'(rq1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
